watch_set_ctrl: RTL and testbench

- Front-panel controller for the digital watch. It converts two debounced keys into a mode state machine.
- It generates single-cycle increment strobes for the time counter and the alarm register (`minute_set`/`hour_set` inputs), with press-and-hold auto-repeat and an idle timeout.
- It compares the running time against the alarm register and sequences the alarm ring output.
- It sits between the key debouncers and the time/alarm register datapath.

---
 rtl/watch_set_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_set_ctrl.sv
// Watch front-panel controller: key edge detection, mode FSM, set strobes with
// press-and-hold auto-repeat, idle timeout, alarm match and ring sequencing.
module watch_set_ctrl #(
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100,
    parameter int unsigned IDLE_TIMEOUT = 10000,
    parameter int unsigned RING_TICKS   = 30000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_mode,
    input  logic       key_set,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_minute,
    input  logic [5:0] cur_second,
    input  logic [5:0] alm_hour,
    input  logic [5:0] alm_minute,
    output logic       time_hour_set,
    output logic       time_minute_set,
    output logic       alm_hour_set,
    output logic       alm_minute_set,
    output logic [2:0] mode,
    output logic       alarm_en,
    output logic       ring
);

    localparam logic [2:0] ST_NORMAL     = 3'd0;
    localparam logic [2:0] ST_SET_T_HOUR = 3'd1;
    localparam logic [2:0] ST_SET_T_MIN  = 3'd2;
    localparam logic [2:0] ST_SET_A_HOUR = 3'd3;
    localparam logic [2:0] ST_SET_A_MIN  = 3'd4;

    localparam logic [15:0] DELAY_C   = 16'(REPEAT_DELAY);
    localparam logic [15:0] RELOAD_C  = 16'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [15:0] IDLE_C    = 16'(IDLE_TIMEOUT);
    localparam logic [15:0] RING_C    = 16'(RING_TICKS);
    localparam logic [15:0] CNT_MAX_C = 16'hFFFF;

    logic        key_mode_r, key_set_r, match_r, alarm_en_r, ring_r;
    logic [2:0]  state_r;
    logic [3:0]  strobe_r;
    logic [15:0] hold_cnt_r, idle_cnt_r, ring_cnt_r;

    logic        mode_rise_s, set_rise_s, any_rise_s, consume_s;
    logic        act_mode_s, act_set_s, repeat_hit_s, fire_s;
    logic        match_s, match_rise_s, alarm_en_nxt_s, ring_nxt_s;
    logic [2:0]  state_nxt_s;
    logic [3:0]  strobe_nxt_s;
    logic [15:0] hold_inc_s, idle_inc_s, ring_inc_s;
    logic [15:0] hold_nxt_s, idle_nxt_s, ring_cnt_nxt_s;

    function automatic logic [2:0] next_mode(input logic [2:0] st);
        case (st)
            ST_NORMAL:     next_mode = ST_SET_T_HOUR;
            ST_SET_T_HOUR: next_mode = ST_SET_T_MIN;
            ST_SET_T_MIN:  next_mode = ST_SET_A_HOUR;
            ST_SET_A_HOUR: next_mode = ST_SET_A_MIN;
            default:       next_mode = ST_NORMAL;
        endcase
    endfunction

    // Strobe order: {time_hour, time_minute, alm_hour, alm_minute}
    function automatic logic [3:0] strobe_sel(input logic [2:0] st);
        case (st)
            ST_SET_T_HOUR: strobe_sel = 4'b1000;
            ST_SET_T_MIN:  strobe_sel = 4'b0100;
            ST_SET_A_HOUR: strobe_sel = 4'b0010;
            ST_SET_A_MIN:  strobe_sel = 4'b0001;
            default:       strobe_sel = 4'b0000;
        endcase
    endfunction

    // Next-state logic for mode FSM, repeat/idle counters, alarm enable and ring.
    always_comb begin
        mode_rise_s  = key_mode & ~key_mode_r;
        set_rise_s   = key_set & ~key_set_r;
        any_rise_s   = mode_rise_s | set_rise_s;
        // A rise that silences the ring performs no other action.
        consume_s    = ring_r & any_rise_s;
        act_mode_s   = mode_rise_s & ~consume_s;
        act_set_s    = set_rise_s & ~consume_s;
        hold_inc_s   = (hold_cnt_r == CNT_MAX_C) ? hold_cnt_r : hold_cnt_r + 16'd1;
        idle_inc_s   = idle_cnt_r + 16'd1;
        ring_inc_s   = ring_cnt_r + 16'd1;
        repeat_hit_s = key_set & key_set_r & tick & (hold_inc_s == DELAY_C);
        match_s      = alarm_en_r & (cur_hour == alm_hour) & (cur_minute == alm_minute)
                       & (cur_second == 6'd0);
        match_rise_s = match_s & ~match_r;

        state_nxt_s    = state_r;
        hold_nxt_s     = hold_cnt_r;
        idle_nxt_s     = idle_cnt_r;
        alarm_en_nxt_s = alarm_en_r;
        fire_s         = 1'b0;

        case (state_r)
            ST_NORMAL: begin
                hold_nxt_s = 16'd0;
                idle_nxt_s = 16'd0;
                if (act_mode_s) begin
                    state_nxt_s = ST_SET_T_HOUR;
                end else if (act_set_s) begin
                    alarm_en_nxt_s = ~alarm_en_r;
                end else begin
                    alarm_en_nxt_s = alarm_en_r;
                end
            end
            ST_SET_T_HOUR, ST_SET_T_MIN, ST_SET_A_HOUR, ST_SET_A_MIN: begin
                if (act_mode_s) begin
                    state_nxt_s = next_mode(state_r);
                    hold_nxt_s  = 16'd0;
                    idle_nxt_s  = 16'd0;
                end else begin
                    fire_s = act_set_s | repeat_hit_s;
                    if (!key_set) begin
                        hold_nxt_s = 16'd0;
                    end else if (key_set_r && tick) begin
                        hold_nxt_s = repeat_hit_s ? RELOAD_C : hold_inc_s;
                    end else begin
                        hold_nxt_s = hold_cnt_r;
                    end
                    // A held key counts as activity, so auto-repeat never times out.
                    if (any_rise_s || key_set) begin
                        idle_nxt_s = 16'd0;
                    end else if (tick) begin
                        if (idle_inc_s == IDLE_C) begin
                            state_nxt_s = ST_NORMAL;
                            idle_nxt_s  = 16'd0;
                        end else begin
                            idle_nxt_s = idle_inc_s;
                        end
                    end else begin
                        idle_nxt_s = idle_cnt_r;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_NORMAL;
                hold_nxt_s  = 16'd0;
                idle_nxt_s  = 16'd0;
            end
        endcase

        strobe_nxt_s = fire_s ? strobe_sel(state_r) : 4'b0000;

        if (match_rise_s) begin
            ring_nxt_s     = 1'b1;
            ring_cnt_nxt_s = 16'd0;
        end else if (!ring_r || any_rise_s) begin
            ring_nxt_s     = 1'b0;
            ring_cnt_nxt_s = 16'd0;
        end else if (!tick) begin
            ring_nxt_s     = 1'b1;
            ring_cnt_nxt_s = ring_cnt_r;
        end else if (ring_inc_s == RING_C) begin
            ring_nxt_s     = 1'b0;
            ring_cnt_nxt_s = 16'd0;
        end else begin
            ring_nxt_s     = 1'b1;
            ring_cnt_nxt_s = ring_inc_s;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_mode_r <= 1'b0;
            key_set_r  <= 1'b0;
            match_r    <= 1'b0;
            alarm_en_r <= 1'b0;
            ring_r     <= 1'b0;
            state_r    <= ST_NORMAL;
            strobe_r   <= 4'b0000;
            hold_cnt_r <= 16'd0;
            idle_cnt_r <= 16'd0;
            ring_cnt_r <= 16'd0;
        end else begin
            key_mode_r <= key_mode;
            key_set_r  <= key_set;
            match_r    <= match_s;
            alarm_en_r <= alarm_en_nxt_s;
            ring_r     <= ring_nxt_s;
            state_r    <= state_nxt_s;
            strobe_r   <= strobe_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            idle_cnt_r <= idle_nxt_s;
            ring_cnt_r <= ring_cnt_nxt_s;
        end
    end

    assign time_hour_set   = strobe_r[3];
    assign time_minute_set = strobe_r[2];
    assign alm_hour_set    = strobe_r[1];
    assign alm_minute_set  = strobe_r[0];
    assign mode            = state_r;
    assign alarm_en        = alarm_en_r;
    assign ring            = ring_r;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl: directed scenarios with fixed expectations plus a
// randomized run compared against an abstract cycle model.
module tb_watch_set_ctrl;

    localparam int RD = 4;
    localparam int RR = 2;
    localparam int IT = 20;
    localparam int RT = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_set = 1'b0;
    logic [5:0] cur_hour = 6'd0, cur_minute = 6'd0, cur_second = 6'd0;
    logic [5:0] alm_hour = 6'd0, alm_minute = 6'd0;
    logic       time_hour_set, time_minute_set, alm_hour_set, alm_minute_set;
    logic [2:0] mode;
    logic       alarm_en, ring;
    logic [3:0] stb;
    logic [8:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Model state: mode number, strobe target (0 = none), ticks held, idle ticks, ring ticks left.
    int m_mode, m_strobe, m_held, m_idle, m_left;
    bit m_en, m_ring, m_pkm, m_pks, m_pmatch;

    watch_set_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .IDLE_TIMEOUT(IT), .RING_TICKS(RT)) dut (
        .clock(clock), .reset(reset), .tick(tick), .key_mode(key_mode), .key_set(key_set),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
        .alm_hour(alm_hour), .alm_minute(alm_minute),
        .time_hour_set(time_hour_set), .time_minute_set(time_minute_set),
        .alm_hour_set(alm_hour_set), .alm_minute_set(alm_minute_set),
        .mode(mode), .alarm_en(alarm_en), .ring(ring)
    );

    always #5 clock = ~clock;

    assign stb     = {time_hour_set, time_minute_set, alm_hour_set, alm_minute_set};
    assign dut_vec = {mode, stb, alarm_en, ring};

    task automatic model_reset();
        m_mode = 0; m_strobe = 0; m_held = 0; m_idle = 0; m_left = 0;
        m_en = 0; m_ring = 0; m_pkm = 0; m_pks = 0; m_pmatch = 0;
    endtask

    task automatic model_step();
        bit mr, sr, any, consumed, match, mrise;
        int st;
        mr       = key_mode && !m_pkm;
        sr       = key_set && !m_pks;
        any      = mr || sr;
        consumed = m_ring && any;
        match    = m_en && (cur_hour == alm_hour) && (cur_minute == alm_minute) && (cur_second == 6'd0);
        mrise    = match && !m_pmatch;
        st       = 0;
        if (m_mode == 0) begin
            m_held = 0; m_idle = 0;
            if (mr && !consumed) m_mode = 1;
            else if (sr && !consumed) m_en = !m_en;
        end else if (mr && !consumed) begin
            m_mode = (m_mode + 1) % 5; m_held = 0; m_idle = 0;
        end else begin
            if (sr && !consumed) st = m_mode;
            if (!key_set) m_held = 0;
            else if (m_pks && tick) begin
                m_held++;
                if (m_held == RD || (m_held > RD && (m_held - RD) % RR == 0)) st = m_mode;
            end
            if (any || key_set) m_idle = 0;
            else if (tick) begin
                m_idle++;
                if (m_idle >= IT) begin m_mode = 0; m_idle = 0; end
            end
        end
        m_strobe = st;
        if (mrise) begin
            m_ring = 1; m_left = RT;
        end else if (m_ring) begin
            if (any) m_ring = 0;
            else if (tick) begin
                m_left--;
                if (m_left == 0) m_ring = 0;
            end
        end
        m_pkm = key_mode; m_pks = key_set; m_pmatch = match;
    endtask

    function automatic logic [8:0] model_vec();
        return {3'(m_mode), m_strobe == 1, m_strobe == 2, m_strobe == 3, m_strobe == 4, m_en, m_ring};
    endfunction

    // One clock: model advances on the edge, outputs are sampled 1 time unit later.
    task automatic cyc();
        @(posedge clock);
        if (!reset) model_reset(); else model_step();
        #1;
    endtask

    task automatic press_mode();
        key_mode = 1'b1; cyc(); key_mode = 1'b0; cyc();
    endtask

    task automatic press_set();
        key_set = 1'b1; cyc(); key_set = 1'b0; cyc();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 6'(h); cur_minute = 6'(m); cur_second = 6'(s);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (10) cyc();
        checks++;
        if (dut_vec !== 9'd0) begin errors++; $display("FAIL reset_hold: got %h want 000", dut_vec); end
        reset = 1'b1;
        cyc();
        checks++;
        if (dut_vec !== 9'd0) begin errors++; $display("FAIL reset_release: got %h want 000", dut_vec); end
    endtask

    task automatic test_mode_cycle();
        int exp_m[5] = '{1, 2, 3, 4, 0};
        logic [3:0] seen = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            key_mode = 1'b1; cyc(); seen |= stb;
            checks++;
            if (mode !== 3'(exp_m[i])) begin errors++; $display("FAIL mode_cycle_%0d: got %0d want %0d", i, mode, exp_m[i]); end
            key_mode = 1'b0; cyc(); seen |= stb;
        end
        checks++;
        if (seen !== 4'b0000) begin errors++; $display("FAIL mode_cycle_strobes: got %b want 0000", seen); end
        press_mode(); press_mode();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (mode !== 3'd0) begin errors++; $display("FAIL async_reset: got mode %0d want 0", mode); end
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        checks++;
        if (dut_vec !== 9'd0) begin errors++; $display("FAIL after_async_reset: got %h want 000", dut_vec); end
    endtask

    task automatic test_single_set();
        repeat (4) press_mode();
        key_set = 1'b1; cyc();
        checks++;
        if (stb !== 4'b0001) begin errors++; $display("FAIL single_set_pulse: got %b want 0001", stb); end
        cyc();
        checks++;
        if (stb !== 4'b0000) begin errors++; $display("FAIL single_set_width: got %b want 0000", stb); end
        key_set = 1'b0; cyc();
        checks++;
        if (stb !== 4'b0000) begin errors++; $display("FAIL single_set_release: got %b want 0000", stb); end
        press_mode();
    endtask

    task automatic test_auto_repeat();
        logic [11:0] mask = 12'd0;
        logic [2:0]  other = 3'b000;
        int extra = 0;
        repeat (3) press_mode();
        for (int i = 0; i < 12; i++) begin
            key_set = 1'b1; cyc();
            mask[i] = alm_hour_set;
            other |= {time_hour_set, time_minute_set, alm_minute_set};
        end
        key_set = 1'b0;
        repeat (6) begin cyc(); extra += int'(alm_hour_set); end
        checks++;
        if (mask !== 12'h551) begin errors++; $display("FAIL repeat_pattern: got %h want 551", mask); end
        checks++;
        if (other !== 3'b000) begin errors++; $display("FAIL repeat_other: got %b want 000", other); end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL repeat_release: got %0d want 0", extra); end
        press_mode(); press_mode();
    endtask

    task automatic test_timeout_collision();
        key_mode = 1'b1; cyc(); key_mode = 1'b0;
        checks++;
        if (mode !== 3'd1) begin errors++; $display("FAIL timeout_enter: got %0d want 1", mode); end
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 19) begin
                checks++;
                if (mode !== 3'd1) begin errors++; $display("FAIL timeout_early: got %0d want 1", mode); end
            end
            if (i == 20) begin
                checks++;
                if (mode !== 3'd0) begin errors++; $display("FAIL timeout_expire: got %0d want 0", mode); end
            end
        end
        press_mode(); press_mode();
        key_mode = 1'b1; key_set = 1'b1; cyc();
        checks++;
        if ({mode, stb} !== {3'd3, 4'b0000}) begin errors++; $display("FAIL collision: got mode %0d stb %b want 3 0000", mode, stb); end
        key_mode = 1'b0; key_set = 1'b0; cyc();
        checks++;
        if (stb !== 4'b0000) begin errors++; $display("FAIL collision_after: got %b want 0000", stb); end
        press_mode(); press_mode();
    endtask

    task automatic test_alarm();
        logic retrig = 1'b0;
        alm_hour = 6'd7; alm_minute = 6'd30;
        set_time(7, 29, 59);
        press_set();
        checks++;
        if ({alarm_en, ring, mode} !== {1'b1, 1'b0, 3'd0}) begin errors++; $display("FAIL alarm_arm: got en %b ring %b mode %0d want 1 0 0", alarm_en, ring, mode); end
        set_time(7, 30, 0);
        cyc();
        checks++;
        if (ring !== 1'b1) begin errors++; $display("FAIL alarm_ring_start: got %b want 1", ring); end
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i == 9) begin
                checks++;
                if (ring !== 1'b1) begin errors++; $display("FAIL alarm_ring_hold: got %b want 1", ring); end
            end
            if (i == 10) begin
                checks++;
                if (ring !== 1'b0) begin errors++; $display("FAIL alarm_ring_end: got %b want 0", ring); end
            end
        end
        repeat (20) begin cyc(); retrig |= ring; end
        checks++;
        if (retrig !== 1'b0) begin errors++; $display("FAIL alarm_retrigger: got %b want 0", retrig); end
    endtask

    task automatic test_silence();
        logic rang = 1'b0;
        set_time(7, 29, 59); cyc();
        set_time(7, 30, 0); cyc();
        checks++;
        if (ring !== 1'b1) begin errors++; $display("FAIL silence_start: got %b want 1", ring); end
        repeat (3) cyc();
        key_mode = 1'b1; cyc();
        checks++;
        if ({ring, mode, alarm_en} !== {1'b0, 3'd0, 1'b1}) begin errors++; $display("FAIL silence_key: got ring %b mode %0d en %b want 0 0 1", ring, mode, alarm_en); end
        key_mode = 1'b0; cyc();
        checks++;
        if ({ring, mode} !== {1'b0, 3'd0}) begin errors++; $display("FAIL silence_after: got ring %b mode %0d want 0 0", ring, mode); end
        set_time(7, 31, 0); cyc();
        press_set();
        checks++;
        if (alarm_en !== 1'b0) begin errors++; $display("FAIL disarm: got %b want 0", alarm_en); end
        set_time(7, 29, 59); cyc();
        set_time(7, 30, 0);
        repeat (15) begin cyc(); rang |= ring; end
        checks++;
        if (rang !== 1'b0) begin errors++; $display("FAIL disarmed_ring: got %b want 0", rang); end
    endtask

    task automatic test_random();
        int krate = 8;
        int srate = 8;
        alm_hour = 6'd0; alm_minute = 6'd0;
        set_time(0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                krate = ($urandom_range(0, 2) == 0) ? 40 : 12;
                srate = ($urandom_range(0, 2) == 0) ? 3 : 10;
            end
            if ($urandom_range(0, krate) == 0) key_mode = ~key_mode;
            if ($urandom_range(0, srate) == 0) key_set = ~key_set;
            tick = (n < 1500) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0)  cur_second = 6'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) cur_minute = 6'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) cur_hour = 6'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) begin
                alm_hour = 6'($urandom_range(0, 1)); alm_minute = 6'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 599) == 0) reset = 1'b0;
            else reset = 1'b1;
            cyc();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random_%0d: got mode %0d stb %b en %b ring %b want %h", n, mode, stb, alarm_en, ring, model_vec());
            end
        end
        reset = 1'b1; tick = 1'b1; key_mode = 1'b0; key_set = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mode_cycle();
        test_single_set();
        test_auto_repeat();
        test_timeout_collision();
        test_alarm();
        test_silence();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
